// File: rtl/fft_out_buffer.sv
// Captures one FFT frame in a single edge, scales (and optionally index-reverses) it, then streams
// one complex sample per valid/ready handshake. Define FFT_OUT_ROUND_EN for rounded scaling.
module fft_out_buffer #(
    parameter int WORD_SIZE = 16,
    parameter int LOG2N     = 4,
    parameter int SHIFT     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [(2**LOG2N)*WORD_SIZE-1:0]    data_r,
    input  logic [(2**LOG2N)*WORD_SIZE-1:0]    data_i,
    input  logic                               load,
    input  logic                               inverse,
    input  logic                               out_ready,
    output logic [WORD_SIZE-1:0]               out_re,
    output logic [WORD_SIZE-1:0]               out_im,
    output logic [LOG2N-1:0]                   out_idx,
    output logic                               out_valid,
    output logic                               out_last,
    output logic                               busy,
    output logic                               overrun
);
    localparam int N = 2 ** LOG2N;
    localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);
    localparam logic [WORD_SIZE:0] RndAdd =
        (SHIFT == 0) ? '0 : ((WORD_SIZE + 1)'(1) << (SHIFT - 1));

    typedef enum logic {StIdle, StStream} state_e;

    state_e               state_q, state_d;
    logic                 overrun_q, overrun_d;
    logic [LOG2N-1:0]     idx_q;
    logic [WORD_SIZE-1:0] re_q, im_q;
    logic [WORD_SIZE-1:0] buf_re_q [N];
    logic [WORD_SIZE-1:0] buf_im_q [N];
    logic [WORD_SIZE-1:0] cap_re   [N];
    logic [WORD_SIZE-1:0] cap_im   [N];
    logic                 xfer, at_last, accept;
    logic [LOG2N-1:0]     idx_nxt;

    // Sign-magnitude scaling so negative values move toward zero like positive ones.
    function automatic logic [WORD_SIZE-1:0] scale(input logic [WORD_SIZE-1:0] x);
        logic                 neg;
        logic [WORD_SIZE-1:0] mag;
        logic [WORD_SIZE:0]   sum;
        logic [WORD_SIZE-1:0] res;
        neg = x[WORD_SIZE-1];
        mag = neg ? -x : x;
`ifdef FFT_OUT_ROUND_EN
        sum = {1'b0, mag} + RndAdd;
`else
        sum = {1'b0, mag};
`endif
        sum = sum >> SHIFT;
        res = sum[WORD_SIZE-1:0];
        return neg ? -res : res;
    endfunction

    function automatic int src_point(input int k, input logic inv);
        return inv ? ((N - k) % N) : k;
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            cap_re[k] = scale(data_r[src_point(k, inverse)*WORD_SIZE +: WORD_SIZE]);
            cap_im[k] = scale(data_i[src_point(k, inverse)*WORD_SIZE +: WORD_SIZE]);
        end
    end

    always_comb begin
        xfer      = (state_q == StStream) && out_ready;
        at_last   = (idx_q == LastIdx);
        idx_nxt   = idx_q + LOG2N'(1);
        // A load is only taken when idle or when it coincides with the final transfer.
        accept    = load && ((state_q == StIdle) || (xfer && at_last));
        overrun_d = load && !accept;
        state_d   = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StStream;
            StStream: if (xfer && at_last && !accept) state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                buf_re_q[k] <= '0;
                buf_im_q[k] <= '0;
            end
            idx_q <= '0;
            re_q  <= '0;
            im_q  <= '0;
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                buf_re_q[k] <= cap_re[k];
                buf_im_q[k] <= cap_im[k];
            end
            idx_q <= '0;
            re_q  <= cap_re[0];
            im_q  <= cap_im[0];
        end else if (xfer && !at_last) begin
            idx_q <= idx_nxt;
            re_q  <= buf_re_q[idx_nxt];
            im_q  <= buf_im_q[idx_nxt];
        end
    end

    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_idx   = idx_q;
    assign out_valid = (state_q == StStream);
    assign busy      = (state_q == StStream);
    assign out_last  = out_valid && at_last;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_fft_out_buffer.sv
// Randomized bench for fft_out_buffer: a sample-queue reference model predicts every output
// cycle; directed phases cover ordering, scaling corners, back-pressure, overrun and reset.
module tb_fft_out_buffer;
    localparam int W     = 16;
    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int SHIFT = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] data_r, data_i;
    logic           load, inverse, out_ready;
    logic [W-1:0]   out_re, out_im;
    logic [LOG2N-1:0] out_idx;
    logic           out_valid, out_last, busy, overrun;

    fft_out_buffer #(.WORD_SIZE(W), .LOG2N(LOG2N), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .data_r(data_r), .data_i(data_i), .load(load),
        .inverse(inverse), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_valid(out_valid), .out_last(out_last), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        int           idx;
    } samp_t;

    samp_t        q[$];
    logic [W-1:0] last_re, last_im;
    logic         exp_ovr;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference scaling with integer arithmetic (division truncates toward zero).
    function automatic logic [W-1:0] ref_scale(input logic [W-1:0] x);
        int v, mag, r;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
`ifdef FFT_OUT_ROUND_EN
        if (SHIFT > 0) mag = mag + (2 ** SHIFT) / 2;
`endif
        r = mag / (2 ** SHIFT);
        if (v < 0) r = -r;
        return W'(r);
    endfunction

    task automatic new_data();
        for (int k = 0; k < N; k++) begin
            data_r[k*W +: W] = W'($urandom);
            data_i[k*W +: W] = W'($urandom);
        end
    endtask

    task automatic check_outputs();
        logic v;
        v = (q.size() != 0);
        check_eq("valid", out_valid, v);
        check_eq("busy", busy, v);
        check_eq("overrun", overrun, exp_ovr);
        if (v) begin
            check_eq("re", out_re, q[0].re);
            check_eq("im", out_im, q[0].im);
            check_eq("idx", out_idx, q[0].idx);
            check_eq("last", out_last, q[0].idx == N - 1);
        end else begin
            check_eq("re_hold", out_re, last_re);
            check_eq("im_hold", out_im, last_im);
            check_eq("last_idle", out_last, 1'b0);
        end
    endtask

    // Apply inputs for one edge, predict the result, then check it on the next falling edge.
    task automatic step(input logic ld, input logic inv, input logic rdy);
        samp_t s;
        int    p;
        load = ld; inverse = inv; out_ready = rdy;
        if (q.size() != 0 && rdy) begin
            last_re = q[0].re;
            last_im = q[0].im;
            void'(q.pop_front());
        end
        exp_ovr = ld && (q.size() != 0);
        if (ld && q.size() == 0) begin
            for (int k = 0; k < N; k++) begin
                p     = inv ? (N - k) % N : k;
                s.re  = ref_scale(data_r[p*W +: W]);
                s.im  = ref_scale(data_i[p*W +: W]);
                s.idx = k;
                q.push_back(s);
            end
        end
        @(negedge clk);
        load = 1'b0;
        check_outputs();
    endtask

    task automatic run_to(input int target);
        for (int g = 0; g < 64 && q.size() != 0 && q[0].idx != target; g++) step(0, 0, 1);
    endtask

    task automatic drain();
        for (int g = 0; g < 64 && q.size() != 0; g++) step(0, 0, 1);
        check_eq("drained", busy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, out_valid, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_ovr"}, overrun, 1'b0);
        check_eq({tag, "_last"}, out_last, 1'b0);
        check_eq({tag, "_re"}, out_re, 0);
        check_eq({tag, "_im"}, out_im, 0);
        check_eq({tag, "_idx"}, out_idx, 0);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; inverse = 1'b0; out_ready = 1'b0;
        data_r = '0; data_i = '0;
        last_re = '0; last_im = '0; exp_ovr = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Index-reversed ramp: expect 0,15,14,...,1.
        for (int k = 0; k < N; k++) data_r[k*W +: W] = W'(16 * k);
        data_i = '0;
        step(1, 1, 1);
        for (int k = 0; k < N; k++) begin
            check_eq("ramp_re", out_re, (k == 0) ? 0 : N - k);
            check_eq("ramp_last", out_last, k == N - 1);
            step(0, 0, 1);
        end
        check_eq("ramp_busy_fall", busy, 1'b0);

        // Scaling corners: small negative and most-negative word.
        data_r = '0;
        data_r[0*W +: W] = 16'hFFF1;
        data_r[1*W +: W] = 16'h8000;
        step(1, 0, 1);
`ifdef FFT_OUT_ROUND_EN
        check_eq("scale_fff1", out_re, 16'hFFFF);
`else
        check_eq("scale_fff1", out_re, 16'h0000);
`endif
        step(0, 0, 1);
        check_eq("scale_8000", out_re, 16'hF800);
        drain();

        // Back-pressure at index 5.
        new_data();
        step(1, 0, 1);
        run_to(5);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            check_eq("stall_idx", out_idx, 5);
        end
        step(0, 0, 1);
        check_eq("resume_idx", out_idx, 6);
        drain();

        // Rejected load at index 8 with fresh data on the bus.
        new_data();
        step(1, 1, 1);
        run_to(8);
        new_data();
        step(1, 0, 0);
        check_eq("overrun_pulse", overrun, 1'b1);
        step(0, 0, 1);
        check_eq("overrun_clear", overrun, 1'b0);
        drain();

        // Back-to-back frames: load with the final transfer.
        new_data();
        step(1, 0, 1);
        run_to(N - 1);
        new_data();
        step(1, 1, 1);
        check_eq("b2b_valid", out_valid, 1'b1);
        check_eq("b2b_idx", out_idx, 0);
        check_eq("b2b_ovr", overrun, 1'b0);
        drain();

        // Asynchronous reset mid-stream.
        new_data();
        step(1, 0, 1);
        run_to(7);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        q.delete();
        last_re = '0; last_im = '0; exp_ovr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();
        new_data();
        step(1, 0, 1);
        check_eq("post_rst_idx", out_idx, 0);
        drain();

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) new_data();
            step($urandom_range(0, 4) == 0, 1'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
